// File: rtl/dzcpu_useq_pkg.sv
// Shared dzcpu_useq definitions: sequencing command codes, condition codes,
// state encodings and flag bit positions, plus the condition evaluator.
package dzcpu_useq_pkg;

  localparam logic [2:0] SEQ_NEXT = 3'd0;
  localparam logic [2:0] SEQ_JMP  = 3'd1;
  localparam logic [2:0] SEQ_CALL = 3'd2;
  localparam logic [2:0] SEQ_RET  = 3'd3;
  localparam logic [2:0] SEQ_JCB  = 3'd4;
  localparam logic [2:0] SEQ_EOF  = 3'd5;

  localparam logic [2:0] COND_ALWAYS = 3'd0;
  localparam logic [2:0] COND_Z      = 3'd1;
  localparam logic [2:0] COND_NZ     = 3'd2;
  localparam logic [2:0] COND_C      = 3'd3;
  localparam logic [2:0] COND_NC     = 3'd4;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_END  = 2'd2
  } state_e;

  // Codes 5..7 are "never", so a branch carrying them falls through as NEXT.
  function automatic logic cond_true(input logic [2:0] cond, input logic [3:0] flags);
    case (cond)
      COND_ALWAYS: return 1'b1;
      COND_Z:      return flags[FLAG_Z];
      COND_NZ:     return ~flags[FLAG_Z];
      COND_C:      return flags[FLAG_C];
      COND_NC:     return ~flags[FLAG_C];
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dzcpu_ustack.sv
// Micro-call LIFO (DEPTH x W) with synchronous clear; only the pointer is reset.
// Instantiated by dzcpu_useq only when DZCPU_USEQ_STACK_EN is defined.
module dzcpu_ustack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         iClock,
  input  logic         iReset,
  input  logic         iClr,
  input  logic         iPush,
  input  logic         iPop,
  input  logic [W-1:0] iData,
  output logic [W-1:0] oTop,
  output logic         oFull,
  output logic         oEmpty
);

  localparam int PW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] sp_q;

  assign oFull  = (sp_q == PW'(DEPTH));
  assign oEmpty = (sp_q == '0);

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset)                 sp_q <= '0;
    else if (iClr)              sp_q <= '0;
    else if (iPush && !oFull)   sp_q <= sp_q + 1'b1;
    else if (iPop  && !oEmpty)  sp_q <= sp_q - 1'b1;
  end

  always_ff @(posedge iClock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (iPush && !oFull && !iClr && (PW'(i) == sp_q)) mem_q[i] <= iData;
    end
  end

  always_comb begin
    oTop = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (PW'(i + 1) == sp_q) oTop = mem_q[i];
    end
  end

endmodule

// File: rtl/dzcpu_useq.sv
// dzcpu microcode sequencer: micro-PC, flow FSM, conditional branches, stalls.
// Define DZCPU_USEQ_STACK_EN to enable CALL/RET with the micro-call stack.
module dzcpu_useq
  import dzcpu_useq_pkg::*;
#(
  parameter int UPC_W       = 8,
  parameter int STACK_DEPTH = 4,
  parameter int CNT_W       = 6
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iStart,
  input  logic [UPC_W-1:0] iFlowIdx,
  input  logic [UPC_W-1:0] iCbFlowIdx,
  input  logic [2:0]       iSeqCmd,
  input  logic [2:0]       iSeqCond,
  input  logic [UPC_W-1:0] iSeqTarget,
  input  logic [3:0]       iFlags,
  input  logic             iMemUop,
  input  logic             iMemReady,
  output logic [UPC_W-1:0] oUpc,
  output logic             oFlowEnable,
  output logic             oBusy,
  output logic             oEof,
  output logic [CNT_W-1:0] oCycles,
  output logic             oStackErr
);

  state_e           state_q, state_d;
  logic [UPC_W-1:0] upc_q, upc_d, upc_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             stall, take;

  assign stall   = (state_q == ST_RUN) & iMemUop & ~iMemReady;
  assign take    = cond_true(iSeqCond, iFlags);
  assign upc_inc = upc_q + 1'b1;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

`ifdef DZCPU_USEQ_STACK_EN
  logic             err_q, err_d;
  logic             push, pop, stk_clr, stk_full, stk_empty;
  logic [UPC_W-1:0] stk_top;

  dzcpu_ustack #(.DEPTH(STACK_DEPTH), .W(UPC_W)) u_stack (
    .iClock (iClock),
    .iReset (iReset),
    .iClr   (stk_clr),
    .iPush  (push),
    .iPop   (pop),
    .iData  (upc_inc),
    .oTop   (stk_top),
    .oFull  (stk_full),
    .oEmpty (stk_empty)
  );

  assign oStackErr = err_q;
`else
  assign oStackErr = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    upc_d    = upc_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
`ifdef DZCPU_USEQ_STACK_EN
    err_d    = err_q;
    push     = 1'b0;
    pop      = 1'b0;
    stk_clr  = 1'b0;
`endif
    case (state_q)
      ST_RUN: begin
        cnt_d = cnt_inc;
        if (!stall) begin
          upc_d = upc_inc;
          case (iSeqCmd)
            SEQ_JMP: if (take) upc_d = iSeqTarget;
            SEQ_JCB: upc_d = iCbFlowIdx;
            SEQ_EOF: if (take) begin
              upc_d    = upc_q;
              state_d  = ST_END;
              cycles_d = cnt_q;
            end
`ifdef DZCPU_USEQ_STACK_EN
            // Over/underflow aborts the flow with the micro-PC left in place.
            SEQ_CALL: if (take) begin
              if (stk_full) begin
                upc_d    = upc_q;
                err_d    = 1'b1;
                state_d  = ST_END;
                cycles_d = cnt_q;
              end else begin
                push  = 1'b1;
                upc_d = iSeqTarget;
              end
            end
            SEQ_RET: if (take) begin
              if (stk_empty) begin
                upc_d    = upc_q;
                err_d    = 1'b1;
                state_d  = ST_END;
                cycles_d = cnt_q;
              end else begin
                pop   = 1'b1;
                upc_d = stk_top;
              end
            end
`endif
            default: ;
          endcase
        end
      end
      default: begin
        if (iStart) begin
          state_d = ST_RUN;
          upc_d   = iFlowIdx;
          cnt_d   = CNT_W'(1);
`ifdef DZCPU_USEQ_STACK_EN
          stk_clr = 1'b1;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q  <= ST_IDLE;
      upc_q    <= '0;
      cnt_q    <= '0;
      cycles_q <= '0;
`ifdef DZCPU_USEQ_STACK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      upc_q    <= upc_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
`ifdef DZCPU_USEQ_STACK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign oUpc        = upc_q;
  assign oBusy       = (state_q == ST_RUN);
  assign oFlowEnable = oBusy & ~stall;
  assign oEof        = (state_q == ST_END);
  assign oCycles     = cycles_q;

endmodule

// File: tb/tb_dzcpu_useq.sv
// Self-checking bench for dzcpu_useq: directed flows plus randomized traffic
// against a behavioural model; follows DZCPU_USEQ_STACK_EN if defined.
module tb_dzcpu_useq;

  localparam int UPC_W = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int UMOD  = 1 << UPC_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [UPC_W-1:0] flow = '0, cb = '0, tgt = '0;
  logic [2:0]       cmd = '0, cond = '0;
  logic [3:0]       flags = '0;
  logic             mem_uop = 1'b0, mem_rdy = 1'b1;

  logic [UPC_W-1:0] upc;
  logic             fen, busy, eof, serr;
  logic [CNT_W-1:0] cycles;

  int checks = 0;
  int failures = 0;

  dzcpu_useq #(.UPC_W(UPC_W), .STACK_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .iClock      (clk),
    .iReset      (rst),
    .iStart      (start),
    .iFlowIdx    (flow),
    .iCbFlowIdx  (cb),
    .iSeqCmd     (cmd),
    .iSeqCond    (cond),
    .iSeqTarget  (tgt),
    .iFlags      (flags),
    .iMemUop     (mem_uop),
    .iMemReady   (mem_rdy),
    .oUpc        (upc),
    .oFlowEnable (fen),
    .oBusy       (busy),
    .oEof        (eof),
    .oCycles     (cycles),
    .oStackErr   (serr)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a flow is "running" or has "just ended"; the stack is a queue.
  bit m_run, m_end, m_err;
  int m_upc, m_cnt, m_cycles;
  int stk[$];

  function automatic bit cond_ok(input int c, input logic [3:0] f);
    case (c)
      0: return 1'b1;
      1: return f[3];
      2: return !f[3];
      3: return f[0];
      4: return !f[0];
      default: return 1'b0;
    endcase
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_run = 0; m_end = 0; m_err = 0;
      m_upc = 0; m_cnt = 0; m_cycles = 0;
      stk.delete();
    end else if (!m_run) begin
      m_end = 0;
      if (start) begin
        m_run = 1; m_upc = int'(flow); m_cnt = 1;
        stk.delete();
      end
    end else begin
      int  used, eff;
      bit  done;
      used  = m_cnt;
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      if (!(mem_uop && !mem_rdy)) begin
        eff  = int'(cmd);
        done = 0;
        if (eff != 4 && !cond_ok(int'(cond), flags)) eff = 0;
`ifndef DZCPU_USEQ_STACK_EN
        if (eff == 2 || eff == 3) eff = 0;
`endif
        case (eff)
          1: m_upc = int'(tgt);
          4: m_upc = int'(cb);
          5: done = 1;
          2: if (stk.size() >= DEPTH) begin m_err = 1; done = 1; end
             else begin stk.push_back((m_upc + 1) % UMOD); m_upc = int'(tgt); end
          3: if (stk.size() == 0) begin m_err = 1; done = 1; end
             else m_upc = stk.pop_back();
          default: m_upc = (m_upc + 1) % UMOD;
        endcase
        if (done) begin m_run = 0; m_end = 1; m_cycles = used; end
      end
    end
  end

  bit cmp_en = 0;
  initial forever begin
    @(negedge clk);
    if (!rst && cmp_en) begin
      chk("m_busy", int'(busy), int'(m_run));
      chk("m_eof", int'(eof), int'(m_end));
      chk("m_flow_enable", int'(fen), int'(m_run && !(mem_uop && !mem_rdy)));
      chk("m_cycles", int'(cycles), m_cycles);
      chk("m_stack_err", int'(serr), int'(m_err));
      if (m_run) chk("m_upc", int'(upc), m_upc);
    end
  end

  task automatic drv(input bit s, input int f, input int c, input int cm, input int cd,
                     input int t, input int fl, input bit mu, input bit mr);
    start = s; flow = UPC_W'(f); cb = UPC_W'(c); cmd = 3'(cm); cond = 3'(cd);
    tgt = UPC_W'(t); flags = 4'(fl); mem_uop = mu; mem_rdy = mr;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    repeat (3) step();
    chk("rst_upc", int'(upc), 0);
    chk("rst_flow_enable", int'(fen), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_eof", int'(eof), 0);
    chk("rst_cycles", int'(cycles), 0);
    chk("rst_stack_err", int'(serr), 0);
    rst = 1'b0;
    cmp_en = 1;
    step();

    // Basic flow: 0x10 NEXT, 0x11 NEXT, 0x12 EOF.
    drv(1, 'h10, 0, 0, 0, 0, 0, 0, 1); step();
    chk("flow_first_upc", int'(upc), 'h10);
    chk("flow_busy", int'(busy), 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    chk("flow_next1", int'(upc), 'h11);
    step();
    chk("flow_next2", int'(upc), 'h12);
    drv(0, 0, 0, 5, 0, 0, 0, 0, 1); step();
    chk("flow_eof", int'(eof), 1);
    chk("flow_eof_busy", int'(busy), 0);
    chk("flow_cycles", int'(cycles), 3);
    idle(); step();
    chk("flow_eof_pulse", int'(eof), 0);

    // Conditional JMP NZ to 0x40, then JCB to 0xC0, JMP to 0xFF, NEXT wraps.
    drv(1, 'h30, 0, 0, 0, 0, 0, 0, 1); step();
    drv(1, 'h99, 0, 1, 2, 'h40, 'h8, 0, 1); step();
    chk("jmp_nz_not_taken", int'(upc), 'h31);
    chk("start_in_run_ignored", int'(busy), 1);
    drv(0, 0, 0, 1, 2, 'h40, 'h0, 0, 1); step();
    chk("jmp_nz_taken", int'(upc), 'h40);
    drv(0, 0, 'hC0, 4, 7, 0, 0, 0, 1); step();
    chk("jcb_unconditional", int'(upc), 'hC0);
    drv(0, 0, 0, 1, 0, 'hFF, 0, 0, 1); step();
    chk("jmp_ff", int'(upc), 'hFF);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    chk("next_wrap", int'(upc), 'h00);
    drv(0, 0, 0, 5, 0, 0, 0, 0, 1); step();
    chk("jmp_flow_cycles", int'(cycles), 6);

    // Memory stall: three wait cycles at 0x50, then 0x51, then EOF at 0x52.
    drv(1, 'h50, 0, 0, 0, 0, 0, 0, 1); step();
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 1, 0); step();
      chk("stall_upc_hold", int'(upc), 'h50);
      chk("stall_flow_enable", int'(fen), 0);
    end
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1); step();
    chk("stall_release", int'(upc), 'h51);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    drv(0, 0, 0, 5, 0, 0, 0, 0, 1); step();
    chk("stall_cycles", int'(cycles), 6);
    // Back-to-back: new start during the END cycle.
    drv(1, 'h60, 0, 0, 0, 0, 0, 0, 1); step();
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_upc", int'(upc), 'h60);
    drv(0, 0, 0, 5, 0, 0, 0, 0, 1); step();
    chk("b2b_cycles", int'(cycles), 1);
    idle(); step();

    // CALL at 0x20 to 0x80, then RET.
    drv(1, 'h20, 0, 0, 0, 0, 0, 0, 1); step();
    drv(0, 0, 0, 2, 0, 'h80, 0, 0, 1); step();
`ifdef DZCPU_USEQ_STACK_EN
    chk("call_target", int'(upc), 'h80);
    drv(0, 0, 0, 3, 0, 0, 0, 0, 1); step();
    chk("ret_return", int'(upc), 'h21);
    drv(0, 0, 0, 5, 0, 0, 0, 0, 1); step();
    drv(1, 'h00, 0, 0, 0, 0, 0, 0, 1); step();
    for (int i = 0; i < DEPTH; i++) begin
      drv(0, 0, 0, 2, 0, 'h10, 0, 0, 1); step();
    end
    chk("nested_busy", int'(busy), 1);
    step();
    chk("overflow_err", int'(serr), 1);
    chk("overflow_eof", int'(eof), 1);
`else
    chk("call_as_next", int'(upc), 'h21);
    drv(0, 0, 0, 3, 0, 0, 0, 0, 1); step();
    chk("ret_as_next", int'(upc), 'h22);
    chk("no_stack_err", int'(serr), 0);
    drv(0, 0, 0, 5, 0, 0, 0, 0, 1); step();
`endif
    idle(); step();

    // Counter saturation with a long stall.
    drv(1, 'h70, 0, 0, 0, 0, 0, 0, 1); step();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (70) step();
    drv(0, 0, 0, 5, 0, 0, 0, 0, 1); step();
    chk("cycles_saturate", int'(cycles), CMAX);
    idle(); step();

    // Asynchronous reset between edges in the middle of a flow.
    drv(1, 'h90, 0, 0, 0, 0, 0, 0, 1); step();
    drv(0, 0, 0, 2, 0, 'hA0, 0, 0, 1); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    #3 rst = 1'b1;
    #1;
    chk("arst_upc", int'(upc), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_flow_enable", int'(fen), 0);
    chk("arst_eof", int'(eof), 0);
    chk("arst_cycles", int'(cycles), 0);
    chk("arst_stack_err", int'(serr), 0);
    #1 rst = 1'b0;
    drv(1, 'hB0, 0, 0, 0, 0, 0, 0, 1); step();
    chk("restart_upc", int'(upc), 'hB0);
    drv(0, 0, 0, 3, 0, 0, 0, 0, 1); step();
`ifdef DZCPU_USEQ_STACK_EN
    chk("restart_empty_stack", int'(serr), 1);
`else
    chk("restart_ret_next", int'(upc), 'hB1);
`endif
    idle(); step();
    rst = 1'b1; step(); rst = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r, c;
      r = int'($urandom_range(0, 99));
      if      (r < 40) c = 0;
      else if (r < 55) c = 1;
      else if (r < 63) c = 2;
      else if (r < 70) c = 3;
      else if (r < 78) c = 4;
      else if (r < 88) c = 5;
      else             c = int'($urandom_range(6, 7));
      drv(bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
          c, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
          ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 60));
      step();
    end

    idle(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
